// File: rtl/regfile_scoreboard_ctrl.sv
// regfile_scoreboard_ctrl
// Scoreboard and write-port controller for the integer register file.
// It tracks which registers have a write outstanding and stalls decode on
// RAW/WAW hazards or when too many writes are in flight. It merges two
// writeback sources onto the single register-file write port, with the main
// pipe (wb0) always taking priority over the long-latency unit (wb1). It also
// keeps sticky error flags for unexpected writebacks and a stuck-pipeline
// watchdog.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   issue_*_d, flush         decode-stage instruction and redirect kill
//   stall_d                  decode must hold its instruction
//   wb0_*                    main-pipe writeback (always accepted)
//   wb1_*, wb1_ready         long-latency writeback request / accept
//   reg_write_*_d, writeData register-file write port
//   busy_vec, inflight_cnt   scoreboard state
//   err_unexpected_wb        sticky: writeback to a non-busy register
//   err_timeout              sticky: watchdog expired
module regfile_scoreboard_ctrl #(
  parameter int MAX_INFLIGHT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid_d,
  input  logic [4:0]  issue_rs1_d,
  input  logic [4:0]  issue_rs2_d,
  input  logic [1:0]  issue_read_en_d,
  input  logic [4:0]  issue_rd_d,
  input  logic        issue_wr_en_d,
  input  logic        flush,
  output logic        stall_d,
  input  logic        wb0_valid,
  input  logic [4:0]  wb0_addr,
  input  logic [31:0] wb0_data,
  input  logic        wb1_valid,
  input  logic [4:0]  wb1_addr,
  input  logic [31:0] wb1_data,
  output logic        wb1_ready,
  output logic        reg_write_en_d,
  output logic [4:0]  reg_write_addr_d,
  output logic [31:0] writeData,
  output logic [31:0] busy_vec,
  output logic [4:0]  inflight_cnt,
  output logic        err_unexpected_wb,
  output logic        err_timeout
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0]      MAX_CNT  = 5'(MAX_INFLIGHT);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [31:0]     busy_reg, busy_next;
  logic [4:0]      cnt_reg, cnt_next;
  logic [WD_W-1:0] wd_reg, wd_next;
  logic            err_wb_reg, err_wb_next;
  logic            err_to_reg, err_to_next;

  logic            raw, waw, full, fire;
  logic            wb_valid, wb_hit, wb_miss;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;

  // Hazard detection; x0 never creates a dependency.
  always_comb begin
    raw = (issue_read_en_d[0] && issue_rs1_d != 5'd0 && busy_reg[issue_rs1_d]) ||
          (issue_read_en_d[1] && issue_rs2_d != 5'd0 && busy_reg[issue_rs2_d]);
    waw  = issue_wr_en_d && issue_rd_d != 5'd0 && busy_reg[issue_rd_d];
    full = issue_wr_en_d && issue_rd_d != 5'd0 && cnt_reg == MAX_CNT;
    // Outputs are forced quiet while reset is held, independent of inputs.
    stall_d = !rst && issue_valid_d && (raw || waw || full);
    fire    = issue_valid_d && !stall_d && !flush && issue_wr_en_d && issue_rd_d != 5'd0;
  end

  // Fixed-priority write-port mux: wb0 first, wb1 only when wb0 is idle.
  always_comb begin
    wb_valid  = !rst && (wb0_valid || wb1_valid);
    wb1_ready = rst || !wb0_valid;
    wb_addr   = 5'd0;
    wb_data   = 32'd0;
    if (wb_valid) begin
      if (wb0_valid) begin
        wb_addr = wb0_addr;
        wb_data = wb0_data;
      end else begin
        wb_addr = wb1_addr;
        wb_data = wb1_data;
      end
    end
    wb_hit  = wb_valid && wb_addr != 5'd0 && busy_reg[wb_addr];
    wb_miss = wb_valid && wb_addr != 5'd0 && !busy_reg[wb_addr];
  end

  // Per-register busy update. An issue and a writeback in the same cycle
  // never hit the same register (WAW would have stalled the issue).
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] = (busy_reg[gi] && !(wb_hit && wb_addr == 5'(gi))) ||
                               (fire && issue_rd_d == 5'(gi));
      end
    end
  endgenerate

  // Count tracks popcount(busy): it moves only on a real set or a real clear.
  always_comb begin
    cnt_next = cnt_reg + 5'(fire) - 5'(wb_hit);

    // Watchdog: any real-address writeback (even an unexpected one) or an
    // empty scoreboard restarts it; an x0 writeback just pauses it.
    wd_next = wd_reg;
    if (cnt_reg == 5'd0 || (wb_valid && wb_addr != 5'd0)) begin
      wd_next = '0;
    end else if (!wb_valid && wd_reg != WD_LIMIT) begin
      wd_next = wd_reg + WD_W'(1);
    end

    err_wb_next = err_wb_reg || wb_miss;
    err_to_next = err_to_reg || (wd_next == WD_LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg   <= '0;
      cnt_reg    <= '0;
      wd_reg     <= '0;
      err_wb_reg <= 1'b0;
      err_to_reg <= 1'b0;
    end else begin
      busy_reg   <= busy_next;
      cnt_reg    <= cnt_next;
      wd_reg     <= wd_next;
      err_wb_reg <= err_wb_next;
      err_to_reg <= err_to_next;
    end
  end

  assign reg_write_en_d    = wb_valid;
  assign reg_write_addr_d  = wb_addr;
  assign writeData         = wb_data;
  assign busy_vec          = busy_reg;
  assign inflight_cnt      = cnt_reg;
  assign err_unexpected_wb = err_wb_reg;
  assign err_timeout       = err_to_reg;

endmodule

// File: tb/tb_regfile_scoreboard_ctrl.sv
// Self-checking bench for regfile_scoreboard_ctrl. Expected write-port
// contents are queued when writebacks are driven and popped when the port is
// sampled; scoreboard state is checked against constants derived by hand.
module tb_regfile_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_d;
  logic [4:0]  issue_rs1_d, issue_rs2_d, issue_rd_d;
  logic [1:0]  issue_read_en_d;
  logic        issue_wr_en_d, flush, stall_d;
  logic        wb0_valid, wb1_valid, wb1_ready;
  logic [4:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        reg_write_en_d;
  logic [4:0]  reg_write_addr_d;
  logic [31:0] writeData, busy_vec;
  logic [4:0]  inflight_cnt;
  logic        err_unexpected_wb, err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rdy;
  } port_t;
  port_t exp_q[$];
  port_t e;

  regfile_scoreboard_ctrl #(.MAX_INFLIGHT(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .issue_valid_d(issue_valid_d), .issue_rs1_d(issue_rs1_d),
    .issue_rs2_d(issue_rs2_d), .issue_read_en_d(issue_read_en_d),
    .issue_rd_d(issue_rd_d), .issue_wr_en_d(issue_wr_en_d),
    .flush(flush), .stall_d(stall_d),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .wb1_ready(wb1_ready),
    .reg_write_en_d(reg_write_en_d), .reg_write_addr_d(reg_write_addr_d),
    .writeData(writeData), .busy_vec(busy_vec), .inflight_cnt(inflight_cnt),
    .err_unexpected_wb(err_unexpected_wb), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid_d = 0; issue_rs1_d = 0; issue_rs2_d = 0; issue_read_en_d = 0;
    issue_rd_d = 0; issue_wr_en_d = 0; flush = 0;
    wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
    wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
  endtask

  task automatic drive_issue(input logic [4:0] rd);
    issue_valid_d = 1; issue_wr_en_d = 1; issue_rd_d = rd; issue_read_en_d = 0;
  endtask

  task automatic push_exp(input logic en, input logic [4:0] a, input logic [31:0] d, input logic r);
    port_t p;
    p.en = en; p.addr = a; p.data = d; p.rdy = r;
    exp_q.push_back(p);
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    wb0_valid = 1; wb0_addr = 5'd3; wb0_data = 32'h5;
    issue_valid_d = 1; issue_wr_en_d = 1; issue_rd_d = 5'd4;
    repeat (2) tick();
    n_checks++;
    if ({busy_vec, inflight_cnt, err_unexpected_wb, err_timeout} !== 39'd0)
      $display("FAIL reset_state: busy=%h cnt=%0d eu=%b et=%b required all zero",
               busy_vec, inflight_cnt, err_unexpected_wb, err_timeout);
    n_checks++;
    if ({stall_d, wb1_ready, reg_write_en_d} !== 3'b010)
      $display("FAIL reset_outputs: stall=%b wb1_ready=%b wen=%b required 0 1 0",
               stall_d, wb1_ready, reg_write_en_d);
    if ({busy_vec, inflight_cnt, err_unexpected_wb, err_timeout} !== 39'd0 ||
        {stall_d, wb1_ready, reg_write_en_d} !== 3'b010) n_fail++;
    idle();
    tick();
    rst = 0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_raw();
    drive_issue(5'd5);
    #2;
    n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL raw_first_issue: stall=%b required 0", stall_d); end
    tick();
    n_checks++;
    if (busy_vec !== 32'h20 || inflight_cnt !== 5'd1) begin
      n_fail++; $display("FAIL raw_busy_set: busy=%h cnt=%0d required 00000020 1", busy_vec, inflight_cnt);
    end
    issue_wr_en_d = 0; issue_rd_d = 0; issue_rs1_d = 5'd5; issue_read_en_d = 2'b01;
    #2;
    n_checks++;
    if (stall_d !== 1'b1) begin n_fail++; $display("FAIL raw_stall: stall=%b required 1", stall_d); end
    tick();
    wb0_valid = 1; wb0_addr = 5'd5; wb0_data = 32'hCAFE_0005;
    push_exp(1, 5'd5, 32'hCAFE_0005, 0);
    #2;
    n_checks++;
    if (stall_d !== 1'b1) begin n_fail++; $display("FAIL raw_stall_wb_cycle: stall=%b required 1", stall_d); end
    e = exp_q.pop_front();
    n_checks++;
    if ({reg_write_en_d, reg_write_addr_d, writeData, wb1_ready} !== {e.en, e.addr, e.data, e.rdy}) begin
      n_fail++; $display("FAIL raw_port: en=%b a=%0d d=%h rdy=%b required en=%b a=%0d d=%h rdy=%b",
        reg_write_en_d, reg_write_addr_d, writeData, wb1_ready, e.en, e.addr, e.data, e.rdy);
    end
    tick();
    wb0_valid = 0;
    #2;
    n_checks++;
    if (stall_d !== 1'b0 || busy_vec !== 32'd0 || inflight_cnt !== 5'd0) begin
      n_fail++; $display("FAIL raw_release: stall=%b busy=%h cnt=%0d required 0 00000000 0",
        stall_d, busy_vec, inflight_cnt);
    end
    idle();
    tick();
    $display("raw: done");
  endtask

  task automatic test_arb();
    drive_issue(5'd3); tick();
    drive_issue(5'd7); tick();
    idle();
    wb0_valid = 1; wb0_addr = 5'd3; wb0_data = 32'hAAAA_0001;
    wb1_valid = 1; wb1_addr = 5'd7; wb1_data = 32'h0000_1234;
    push_exp(1, 5'd3, 32'hAAAA_0001, 0);
    push_exp(1, 5'd7, 32'h0000_1234, 1);
    push_exp(0, 5'd0, 32'h0, 1);
    for (int c = 0; c < 3; c++) begin
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({reg_write_en_d, reg_write_addr_d, writeData, wb1_ready} !== {e.en, e.addr, e.data, e.rdy}) begin
        n_fail++; $display("FAIL arb_port_%0d: en=%b a=%0d d=%h rdy=%b required en=%b a=%0d d=%h rdy=%b",
          c, reg_write_en_d, reg_write_addr_d, writeData, wb1_ready, e.en, e.addr, e.data, e.rdy);
      end
      $display("arb: cycle %0d en=%b addr=%0d data=%h", c, reg_write_en_d, reg_write_addr_d, writeData);
      tick();
      if (c == 0) wb0_valid = 0;
      if (c == 1) wb1_valid = 0;
    end
    n_checks++;
    if (busy_vec !== 32'd0 || inflight_cnt !== 5'd0 || err_unexpected_wb !== 1'b0) begin
      n_fail++; $display("FAIL arb_drain: busy=%h cnt=%0d eu=%b required 00000000 0 0",
        busy_vec, inflight_cnt, err_unexpected_wb);
    end
  endtask

  task automatic test_full();
    for (int r = 1; r <= 4; r++) begin
      drive_issue(5'(r));
      tick();
    end
    n_checks++;
    if (inflight_cnt !== 5'd4 || busy_vec !== 32'h1E) begin
      n_fail++; $display("FAIL full_fill: cnt=%0d busy=%h required 4 0000001e", inflight_cnt, busy_vec);
    end
    drive_issue(5'd0);
    #2;
    n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL full_x0_nostall: stall=%b required 0", stall_d); end
    drive_issue(5'd9);
    wb0_valid = 1; wb0_addr = 5'd2; wb0_data = 32'h2;
    #2;
    n_checks++;
    if (stall_d !== 1'b1) begin n_fail++; $display("FAIL full_stall: stall=%b required 1", stall_d); end
    tick();
    wb0_valid = 0;
    #2;
    n_checks++;
    if (stall_d !== 1'b0 || inflight_cnt !== 5'd3) begin
      n_fail++; $display("FAIL full_freed: stall=%b cnt=%0d required 0 3", stall_d, inflight_cnt);
    end
    tick();
    n_checks++;
    if (inflight_cnt !== 5'd4 || busy_vec !== 32'h21A) begin
      n_fail++; $display("FAIL full_refire: cnt=%0d busy=%h required 4 0000021a", inflight_cnt, busy_vec);
    end
    issue_valid_d = 0;
    wb0_valid = 1; wb0_addr = 5'd1;
    tick();
    // Same-cycle issue and writeback: count must not move.
    drive_issue(5'd11);
    wb0_addr = 5'd3;
    tick();
    n_checks++;
    if (inflight_cnt !== 5'd3 || busy_vec !== 32'hA10) begin
      n_fail++; $display("FAIL full_simul: cnt=%0d busy=%h required 3 00000a10", inflight_cnt, busy_vec);
    end
    issue_valid_d = 0;
    wb0_addr = 5'd4; tick();
    wb0_addr = 5'd9; tick();
    wb0_addr = 5'd11; tick();
    idle();
    n_checks++;
    if (inflight_cnt !== 5'd0 || busy_vec !== 32'd0 || err_unexpected_wb !== 1'b0) begin
      n_fail++; $display("FAIL full_drain: cnt=%0d busy=%h eu=%b required 0 00000000 0",
        inflight_cnt, busy_vec, err_unexpected_wb);
    end
    $display("full: done");
  endtask

  task automatic test_flush_x0();
    drive_issue(5'd8);
    flush = 1;
    #2;
    n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL flush_stall: stall=%b required 0", stall_d); end
    tick();
    idle();
    n_checks++;
    if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL flush_busy: busy=%h required 00000000", busy_vec); end
    drive_issue(5'd0);
    issue_rs1_d = 5'd0; issue_rs2_d = 5'd0; issue_read_en_d = 2'b11;
    #2;
    n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL x0_stall: stall=%b required 0", stall_d); end
    tick();
    idle();
    n_checks++;
    if (busy_vec !== 32'd0 || inflight_cnt !== 5'd0) begin
      n_fail++; $display("FAIL x0_busy: busy=%h cnt=%0d required 00000000 0", busy_vec, inflight_cnt);
    end
    wb0_valid = 1; wb0_addr = 5'd0; wb0_data = 32'h1111;
    push_exp(1, 5'd0, 32'h1111, 0);
    #2;
    e = exp_q.pop_front();
    n_checks++;
    if ({reg_write_en_d, reg_write_addr_d, writeData, wb1_ready} !== {e.en, e.addr, e.data, e.rdy}) begin
      n_fail++; $display("FAIL x0_port: en=%b a=%0d d=%h rdy=%b required en=%b a=%0d d=%h rdy=%b",
        reg_write_en_d, reg_write_addr_d, writeData, wb1_ready, e.en, e.addr, e.data, e.rdy);
    end
    tick();
    idle();
    n_checks++;
    if (err_unexpected_wb !== 1'b0) begin n_fail++; $display("FAIL x0_wb_err: eu=%b required 0", err_unexpected_wb); end
    $display("flush_x0: done");
  endtask

  task automatic test_unexpected();
    wb1_valid = 1; wb1_addr = 5'd10; wb1_data = 32'hBEEF;
    push_exp(1, 5'd10, 32'hBEEF, 1);
    #2;
    e = exp_q.pop_front();
    n_checks++;
    if ({reg_write_en_d, reg_write_addr_d, writeData, wb1_ready} !== {e.en, e.addr, e.data, e.rdy}) begin
      n_fail++; $display("FAIL unexp_port: en=%b a=%0d d=%h rdy=%b required en=%b a=%0d d=%h rdy=%b",
        reg_write_en_d, reg_write_addr_d, writeData, wb1_ready, e.en, e.addr, e.data, e.rdy);
    end
    tick();
    idle();
    n_checks++;
    if (err_unexpected_wb !== 1'b1 || inflight_cnt !== 5'd0 || busy_vec !== 32'd0) begin
      n_fail++; $display("FAIL unexp_set: eu=%b cnt=%0d busy=%h required 1 0 00000000",
        err_unexpected_wb, inflight_cnt, busy_vec);
    end
    repeat (3) tick();
    n_checks++;
    if (err_unexpected_wb !== 1'b1) begin n_fail++; $display("FAIL unexp_sticky: eu=%b required 1", err_unexpected_wb); end
    $display("unexpected: done");
  endtask

  task automatic test_timeout_reset();
    drive_issue(5'd6);
    tick();
    idle();
    repeat (63) tick();
    n_checks++;
    if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: et=%b required 0 after 63 cycles", err_timeout); end
    tick();
    n_checks++;
    if (err_timeout !== 1'b1 || busy_vec !== 32'h40) begin
      n_fail++; $display("FAIL timeout_set: et=%b busy=%h required 1 00000040", err_timeout, busy_vec);
    end
    #2;
    rst = 1;
    #1;
    n_checks++;
    if ({busy_vec, inflight_cnt, err_timeout, err_unexpected_wb} !== 39'd0) begin
      n_fail++; $display("FAIL async_reset: busy=%h cnt=%0d et=%b eu=%b required all zero",
        busy_vec, inflight_cnt, err_timeout, err_unexpected_wb);
    end
    tick();
    rst = 0;
    tick();
    $display("timeout_reset: done");
  endtask

  initial begin
    test_reset();
    test_raw();
    test_arb();
    test_full();
    test_flush_x0();
    test_unexpected();
    test_timeout_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
